lfsr_prng_stream: RTL
=====================

// Module: lfsr_prng_stream
// PURPOSE
//  Parametrised Galois-LFSR pseudo-random word source with a valid/ready output stream.
//  Generalises the fixed-width PRNG with runtime seed load, zero-seed protection, enable
//  gating, backpressure stall and a word counter. Feeds event-save/UFM scrambling and test-pattern consumers.
// PARAMETERS
//  LFSR_W       32             LFSR state width (4..64)
//  OUT_W        32             output word width; one LFSR shift yields one output bit
//  TAPS         32'h8020_0003  Galois feedback mask, LFSR_W bits, must be maximal-length
//  SEED_DEFAULT all ones       state loaded at reset and on zero-seed/lockup recovery; nonzero
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous, active-high reset
//  en         in   1       run enable; low freezes LFSR, accumulator and bit count
//  seed_load  in   1       one-cycle strobe: load seed_in
//  seed_in    in   LFSR_W  new seed value
//  rnd_data   out  OUT_W   random word; stable while rnd_valid && !rnd_ready
//  rnd_valid  out  1       rnd_data holds an unconsumed word
//  rnd_ready  in   1       consumer accepts the word on clk edge when rnd_valid && rnd_ready
//  seed_err   out  1       one-cycle pulse: zero seed rejected or all-zero lockup recovered
//  word_cnt   out  32      count of accepted words; wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset: lfsr=SEED_DEFAULT, acc=0, bit_cnt=0, rnd_data=0, rnd_valid=0, seed_err=0, word_cnt=0, state=IDLE.
//  Shift step: bit=lfsr[0]; lfsr_next=(lfsr>>1)^(lfsr[0]?TAPS:0); acc={acc[OUT_W-2:0],bit}; bit_cnt++.
//  Slot free: !rnd_valid || rnd_ready (same-cycle consume and refill is allowed).
//  FSM:
//   IDLE : en=0. No shift. en=1 -> RUN.
//   RUN  : shift every cycle. On the shift where bit_cnt==OUT_W-1 and slot free: rnd_data={acc[OUT_W-2:0],bit},
//          rnd_valid=1, bit_cnt=0. Same condition with slot not free: no shift -> STALL.
//          en=0 -> IDLE, keeping bit_cnt and acc (no bits lost).
//   STALL: hold all state. Slot free -> perform the pending completing shift and load the word -> RUN.
//          en=0 -> IDLE; the completing shift stays pending.
//  Latency: with en=1 and the slot free, rnd_valid rises exactly OUT_W edges after en is sampled high.
//   Steady state with rnd_ready=1: one word per OUT_W cycles.
//  Handshake: rnd_valid drops the cycle after acceptance unless the same edge loads a new word.
//   rnd_valid never drops without acceptance, except on seed_load.
//  seed_load has priority over en, the shift and the handshake.
//   Action: lfsr=seed_in (or SEED_DEFAULT if seed_in==0, with seed_err=1); acc=0, bit_cnt=0,
//   rnd_valid=0 (pending word discarded), state=RUN if en else IDLE. word_cnt is not changed.
//  Lockup guard: lfsr==0 in any state (SEU) -> reload SEED_DEFAULT next edge, pulse seed_err.
//  word_cnt increments on each rnd_valid&&rnd_ready edge, including one coincident with seed_load
//   (that word is accepted before the flush).
//  rst mid-operation: immediate return to the reset values; no partial word is emitted afterwards.
// STRUCTURE
//  lfsr_prng_pkg: state enum {IDLE,RUN,STALL}; maximal TAPS constants for widths 4/8/16/32/64
//   (4'hC, 8'hB8, 16'hB400, 32'h8020_0003, 64'hD800_0000_0000_0000).
//  Sub-module lfsr_galois_step: combinational one-step next-state + output bit for (LFSR_W,TAPS).
//   Instantiated once; top holds the FSM, accumulator, output register and counter.
//  Elaboration checks: OUT_W>=1, LFSR_W>=4, TAPS[LFSR_W-1]==1, SEED_DEFAULT!=0.
// TESTING
//  1 Period, LFSR_W=4, TAPS=4'hC, OUT_W=1, seed 4'h1, ready=1: bit stream repeats every 15 words;
//    all 15 nonzero states visited; state 0 is never reached.
//  2 Latency/throughput, defaults, ready=1, en raised at cycle 0: first rnd_valid at edge 32;
//    word_cnt=10 after 320 cycles; data matches a C model of the Galois step.
//  3 Backpressure: ready=0 for 200 cycles -> rnd_data stable, lfsr frozen at the STALL point, word_cnt unchanged.
//    Then ready=1 -> the next word equals the model word with no bit skipped or repeated.
//  4 Zero seed: seed_load=1, seed_in=0 -> seed_err high exactly 1 cycle, lfsr=SEED_DEFAULT,
//    rnd_valid=0; the next word equals the reset-sequence first word.
//  5 Seed mid-word + en toggle: seed_load at bit_cnt=17 with valid pending -> valid drops, bit_cnt=0.
//    en low 5 cycles mid-word -> the word completes 5 cycles late with identical value.
//  6 Async reset while STALL: rst for 1 cycle -> all outputs 0 / lfsr=SEED_DEFAULT immediately;
//    force lfsr=0 -> seed_err pulse and recovery.

Source files
------------

// File: rtl/lfsr_prng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_prng_pkg
//  Description : Shared constants for the LFSR PRNG stream: FSM state
//                encodings, maximal-length Galois tap masks for common
//                widths and a helper that picks a default mask by width.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_prng_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_STALL = 2'd2;

    // Maximal-length Galois feedback masks (right-shifting form)
    localparam logic [3:0]  c_TAPS_4  = 4'hC;
    localparam logic [7:0]  c_TAPS_8  = 8'hB8;
    localparam logic [15:0] c_TAPS_16 = 16'hB400;
    localparam logic [31:0] c_TAPS_32 = 32'h8020_0003;
    localparam logic [63:0] c_TAPS_64 = 64'hD800_0000_0000_0000;

    // Default mask for a given width; unsupported widths fall back to the
    // 32-bit mask and are caught by the top-level elaboration checks.
    function automatic logic [63:0] default_taps(input int width);
        case (width)
            4:       return 64'(c_TAPS_4);
            8:       return 64'(c_TAPS_8);
            16:      return 64'(c_TAPS_16);
            64:      return c_TAPS_64;
            default: return 64'(c_TAPS_32);
        endcase
    endfunction

endpackage : lfsr_prng_pkg
`default_nettype wire

// File: rtl/lfsr_galois_step.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_galois_step
//  Description : Combinational single step of a right-shifting Galois LFSR.
//                Produces the next state and the bit shifted out.
//  Ports       : i_state  in  LFSR_W  current LFSR state
//                o_next   out LFSR_W  state after one shift
//                o_bit    out 1       output bit of this shift (i_state[0])
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_galois_step
    import lfsr_prng_pkg::*;
#(
    parameter int                LFSR_W = 32,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(default_taps(LFSR_W))
) (
    input  logic [LFSR_W-1:0] i_state,
    output logic [LFSR_W-1:0] o_next,
    output logic              o_bit
);

    assign o_bit  = i_state[0];
    assign o_next = (i_state >> 1) ^ (i_state[0] ? TAPS : {LFSR_W{1'b0}});

endmodule : lfsr_galois_step
`default_nettype wire

// File: rtl/lfsr_prng_stream.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_prng_stream
//  Description : Galois-LFSR pseudo-random word source with a valid/ready
//                output stream. One LFSR shift contributes one output bit;
//                OUT_W bits form a word. Supports runtime seed load with
//                zero-seed protection, enable gating, backpressure stall,
//                all-zero lockup recovery and an accepted-word counter.
//  Ports       : clk        in  1       system clock
//                rst        in  1       asynchronous active-high reset
//                en         in  1       run enable
//                seed_load  in  1       strobe: load seed_in
//                seed_in    in  LFSR_W  new seed
//                rnd_data   out OUT_W   random word
//                rnd_valid  out 1       rnd_data holds an unconsumed word
//                rnd_ready  in  1       consumer accepts the word
//                seed_err   out 1       pulse: zero seed / lockup recovered
//                word_cnt   out 32      count of accepted words
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_prng_stream
    import lfsr_prng_pkg::*;
#(
    parameter int                LFSR_W       = 32,
    parameter int                OUT_W        = 32,
    parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(default_taps(LFSR_W)),
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = {LFSR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [OUT_W-1:0]  rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              seed_err,
    output logic [31:0]       word_cnt
);

    localparam int              c_CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(OUT_W - 1);

    // ------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------
    if (OUT_W < 1) begin : g_chk_out_w
        $error("lfsr_prng_stream: OUT_W must be >= 1");
    end
    if (LFSR_W < 4) begin : g_chk_lfsr_w
        $error("lfsr_prng_stream: LFSR_W must be >= 4");
    end
    if (TAPS[LFSR_W-1] != 1'b1) begin : g_chk_taps
        $error("lfsr_prng_stream: TAPS MSB must be set");
    end
    if (SEED_DEFAULT == '0) begin : g_chk_seed
        $error("lfsr_prng_stream: SEED_DEFAULT must be nonzero");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [LFSR_W-1:0]    r_lfsr;
    logic [OUT_W-1:0]     r_acc;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [OUT_W-1:0]     r_data;
    logic                 r_valid;
    logic                 r_seed_err;
    logic [31:0]          r_word_cnt;

    logic [LFSR_W-1:0]    w_lfsr_next;
    logic                 w_bit;
    logic [OUT_W-1:0]     w_word;
    logic                 w_accept;
    logic                 w_slot_free;
    logic                 w_last;
    logic                 w_hold;
    logic                 w_lockup;
    logic                 w_seed_zero;

    lfsr_galois_step #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_step (
        .i_state (r_lfsr),
        .o_next  (w_lfsr_next),
        .o_bit   (w_bit)
    );

    // Accumulator with the current bit appended; on the completing shift
    // this is the finished word.
    if (OUT_W > 1) begin : g_wide
        assign w_word = {r_acc[OUT_W-2:0], w_bit};
    end else begin : g_narrow
        assign w_word = w_bit;
    end

    assign w_accept    = r_valid && rnd_ready;
    assign w_slot_free = !r_valid || rnd_ready;
    assign w_last      = (r_bit_cnt == c_LAST);
    // The completing shift waits until the output slot can take the word,
    // so no bit is ever shifted out without a place to land.
    assign w_hold      = ((r_state == c_ST_STALL) || w_last) && !w_slot_free;
    assign w_lockup    = (r_lfsr == '0);
    assign w_seed_zero = (seed_in == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_lfsr     <= SEED_DEFAULT;
            r_acc      <= '0;
            r_bit_cnt  <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_seed_err <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_seed_err <= 1'b0;

            // A word handed over on this edge counts even if a seed load
            // flushes the stream at the same time.
            if (w_accept) begin
                r_word_cnt <= r_word_cnt + 32'd1;
            end

            if (seed_load) begin
                r_lfsr     <= w_seed_zero ? SEED_DEFAULT : seed_in;
                r_seed_err <= w_seed_zero;
                r_acc      <= '0;
                r_bit_cnt  <= '0;
                r_valid    <= 1'b0;
                r_state    <= en ? c_ST_RUN : c_ST_IDLE;
            end else begin
                // Cleared here; a word loaded below on this edge re-sets it.
                if (w_accept) begin
                    r_valid <= 1'b0;
                end

                if (w_lockup) begin
                    r_lfsr     <= SEED_DEFAULT;
                    r_seed_err <= 1'b1;
                end else if (!en) begin
                    // Partial word and pending completing shift are kept.
                    r_state <= c_ST_IDLE;
                end else if (w_hold) begin
                    r_state <= c_ST_STALL;
                end else begin
                    r_state <= c_ST_RUN;
                    r_lfsr  <= w_lfsr_next;
                    r_acc   <= w_word;
                    if (w_last) begin
                        r_data    <= w_word;
                        r_valid   <= 1'b1;
                        r_bit_cnt <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                    end
                end
            end
        end
    end

    assign rnd_data  = r_data;
    assign rnd_valid = r_valid;
    assign seed_err  = r_seed_err;
    assign word_cnt  = r_word_cnt;

endmodule : lfsr_prng_stream
`default_nettype wire
